// File: rtl/conv_scheduler.sv
`default_nettype none
// =============================================================================
// conv_scheduler : address/strobe sequencer for a sliding-window convolution
// Rev 1.0
// =============================================================================
module conv_scheduler #(
  parameter int N      = 4,
  parameter int FW     = 4,
  parameter int IW     = 16,
  parameter int STRIDE = 1,
  localparam int P     = (IW - FW) / STRIDE + 1,
  localparam int IN_W  = (IW > 1) ? $clog2(IW) : 1,
  localparam int FA_W  = (FW > 1) ? $clog2(FW) : 1,
  localparam int FS_W  = (N > 1) ? $clog2(N) : 1,
  localparam int OA_W  = (N * P > 1) ? $clog2(N * P) : 1,
  localparam int PC_W  = (P > 1) ? $clog2(P) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            out_ready,
  output logic [IN_W-1:0] in_addr,
  output logic [FA_W-1:0] filt_addr,
  output logic [FS_W-1:0] filt_sel,
  output logic            mac_clr,
  output logic            mac_en,
  output logic            psum_wr,
  output logic [OA_W-1:0] out_addr,
  output logic            busy,
  output logic            done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_MAC   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [FS_W-1:0] f_q, f_d;
  logic [PC_W-1:0] p_q, p_d;
  logic [FA_W-1:0] k_q, k_d;
  logic [IN_W-1:0] base_q, base_d;   // running p*STRIDE
  logic [OA_W-1:0] oidx_q, oidx_d;   // running f*P+p

  logic            mac_clr_q, mac_clr_d;
  logic            mac_en_q, mac_en_d;
  logic            wr_q, wr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [IN_W-1:0] in_addr_q, in_addr_d;
  logic [FA_W-1:0] filt_addr_q, filt_addr_d;
  logic [FS_W-1:0] filt_sel_q, filt_sel_d;
  logic [OA_W-1:0] out_addr_q, out_addr_d;

  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    p_d     = p_q;
    k_d     = k_q;
    base_d  = base_q;
    oidx_d  = oidx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLR;
          f_d     = '0;
          p_d     = '0;
          k_d     = '0;
          base_d  = '0;
          oidx_d  = '0;
        end
      end
      S_CLR: begin
        k_d     = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        if (k_q == FA_W'(FW - 1)) state_d = S_WRITE;
        else                      k_d     = k_q + FA_W'(1);
      end
      S_WRITE: begin
        if (out_ready) begin
          if (p_q != PC_W'(P - 1)) begin
            p_d     = p_q + PC_W'(1);
            base_d  = base_q + IN_W'(STRIDE);
            oidx_d  = oidx_q + OA_W'(1);
            state_d = S_CLR;
          end else if (f_q != FS_W'(N - 1)) begin
            p_d     = '0;
            base_d  = '0;
            f_d     = f_q + FS_W'(1);
            oidx_d  = oidx_q + OA_W'(1);
            state_d = S_CLR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so that every strobe leaves a flop.
    mac_clr_d   = (state_d == S_CLR);
    mac_en_d    = (state_d == S_MAC);
    wr_d        = (state_d == S_WRITE);
    done_d      = (state_d == S_DONE);
    busy_d      = mac_clr_d | mac_en_d | wr_d;
    in_addr_d   = mac_en_d ? (base_d + IN_W'(k_d)) : '0;
    filt_addr_d = mac_en_d ? k_d : '0;
    filt_sel_d  = busy_d ? f_d : '0;
    out_addr_d  = wr_d ? oidx_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      f_q         <= '0;
      p_q         <= '0;
      k_q         <= '0;
      base_q      <= '0;
      oidx_q      <= '0;
      mac_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      wr_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_addr_q   <= '0;
      filt_addr_q <= '0;
      filt_sel_q  <= '0;
      out_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      f_q         <= f_d;
      p_q         <= p_d;
      k_q         <= k_d;
      base_q      <= base_d;
      oidx_q      <= oidx_d;
      mac_clr_q   <= mac_clr_d;
      mac_en_q    <= mac_en_d;
      wr_q        <= wr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      in_addr_q   <= in_addr_d;
      filt_addr_q <= filt_addr_d;
      filt_sel_q  <= filt_sel_d;
      out_addr_q  <= out_addr_d;
    end
  end

  // The write strobe qualifies the registered WRITE flag with the live handshake.
  assign psum_wr   = wr_q & out_ready;
  assign mac_clr   = mac_clr_q;
  assign mac_en    = mac_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign in_addr   = in_addr_q;
  assign filt_addr = filt_addr_q;
  assign filt_sel  = filt_sel_q;
  assign out_addr  = out_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_scheduler.sv
`default_nettype none
// =============================================================================
// tb_conv_scheduler : randomized self-checking bench against an event-list model
// Rev 1.0
// =============================================================================
module tb_conv_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start1, rdy1, start2, rdy2;

  logic [3:0] d1_in_addr;
  logic [1:0] d1_filt_addr, d1_filt_sel;
  logic [5:0] d1_out_addr;
  logic       d1_mac_clr, d1_mac_en, d1_psum_wr, d1_busy, d1_done;

  logic [2:0] d2_in_addr;
  logic [1:0] d2_filt_addr;
  logic [0:0] d2_filt_sel;
  logic [2:0] d2_out_addr;
  logic       d2_mac_clr, d2_mac_en, d2_psum_wr, d2_busy, d2_done;

  conv_scheduler dut_def (
    .clk(clk), .rst(rst), .start(start1), .out_ready(rdy1),
    .in_addr(d1_in_addr), .filt_addr(d1_filt_addr), .filt_sel(d1_filt_sel),
    .mac_clr(d1_mac_clr), .mac_en(d1_mac_en), .psum_wr(d1_psum_wr),
    .out_addr(d1_out_addr), .busy(d1_busy), .done(d1_done)
  );

  conv_scheduler #(.N(2), .FW(4), .IW(8), .STRIDE(2)) dut_small (
    .clk(clk), .rst(rst), .start(start2), .out_ready(rdy2),
    .in_addr(d2_in_addr), .filt_addr(d2_filt_addr), .filt_sel(d2_filt_sel),
    .mac_clr(d2_mac_clr), .mac_en(d2_mac_en), .psum_wr(d2_psum_wr),
    .out_addr(d2_out_addr), .busy(d2_busy), .done(d2_done)
  );

  int checks = 0;
  int errors = 0;

  // Observed outputs of the selected instance, strobes as {clr,en,wr,busy,done}.
  logic [4:0]  o_str;
  logic [31:0] o_in, o_fa, o_fs, o_oa;

  task automatic sample_outputs(input bit sel);
    if (sel) begin
      o_str = {d2_mac_clr, d2_mac_en, d2_psum_wr, d2_busy, d2_done};
      o_in = 32'(d2_in_addr); o_fa = 32'(d2_filt_addr);
      o_fs = 32'(d2_filt_sel); o_oa = 32'(d2_out_addr);
    end else begin
      o_str = {d1_mac_clr, d1_mac_en, d1_psum_wr, d1_busy, d1_done};
      o_in = 32'(d1_in_addr); o_fa = 32'(d1_filt_addr);
      o_fs = 32'(d1_filt_sel); o_oa = 32'(d1_out_addr);
    end
  endtask

  // Kinds: 0 CLR, 1 MAC, 2 WRITE, 3 IDLE (start cycle), 4 DONE.
  // The run is an ordered list of expected cycles; a WRITE repeats while out_ready is low.
  task automatic run_checked(input bit sel, input int n, input int fw, input int iw,
                             input int stride, input int stall_pct, input int noise_pct,
                             input int fix_addr, input int fix_len, input int abort_evt,
                             input string tag);
    int p_cnt;
    int ev_kind[$], ev_in[$], ev_fa[$], ev_fs[$], ev_oa[$];
    int e, cyc, fixcnt, kind;
    bit sv, rdy, c_in, c_fa, c_fs, c_oa, bad;
    logic [4:0]  e_str;
    logic [31:0] e_in, e_fa, e_fs, e_oa;
    p_cnt = (iw - fw) / stride + 1;
    ev_kind.push_back(3); ev_in.push_back(0); ev_fa.push_back(0); ev_fs.push_back(0); ev_oa.push_back(0);
    for (int f = 0; f < n; f++) begin
      for (int p = 0; p < p_cnt; p++) begin
        ev_kind.push_back(0); ev_in.push_back(0); ev_fa.push_back(0); ev_fs.push_back(f); ev_oa.push_back(0);
        for (int k = 0; k < fw; k++) begin
          ev_kind.push_back(1); ev_in.push_back(p * stride + k); ev_fa.push_back(k);
          ev_fs.push_back(f); ev_oa.push_back(0);
        end
        ev_kind.push_back(2); ev_in.push_back(0); ev_fa.push_back(0); ev_fs.push_back(f);
        ev_oa.push_back(f * p_cnt + p);
      end
    end
    ev_kind.push_back(4); ev_in.push_back(0); ev_fa.push_back(0); ev_fs.push_back(0); ev_oa.push_back(0);

    e = 0; cyc = 0; fixcnt = 0;
    while (e < ev_kind.size()) begin
      kind = ev_kind[e];
      sv   = (kind == 3) ? 1'b1 : (int'($urandom_range(0, 99)) < noise_pct);
      rdy  = 1'b1;
      if (kind == 2) begin
        if (ev_oa[e] == fix_addr && fixcnt < fix_len) begin
          rdy = 1'b0; fixcnt++;
        end else if (int'($urandom_range(0, 99)) < stall_pct) begin
          rdy = 1'b0;
        end
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      if (sel) begin start2 = sv; rdy2 = rdy; end else begin start1 = sv; rdy1 = rdy; end
      @(negedge clk);
      sample_outputs(sel);
      e_in = 32'(ev_in[e]); e_fa = 32'(ev_fa[e]); e_fs = 32'(ev_fs[e]); e_oa = 32'(ev_oa[e]);
      c_in = 0; c_fa = 0; c_fs = 0; c_oa = 0;
      case (kind)
        0: e_str = 5'b10010;
        1: begin e_str = 5'b01010; c_in = 1; c_fa = 1; c_fs = 1; end
        2: begin e_str = {2'b00, rdy, 2'b10}; c_fs = 1; c_oa = 1; end
        3: begin e_str = 5'b00000; c_in = 1; c_fa = 1; c_fs = 1; c_oa = 1; end
        default: begin e_str = 5'b00001; c_in = 1; c_fa = 1; c_fs = 1; c_oa = 1; end
      endcase
      bad = (o_str !== e_str) || (c_in && (o_in !== e_in)) || (c_fa && (o_fa !== e_fa)) ||
            (c_fs && (o_fs !== e_fs)) || (c_oa && (o_oa !== e_oa));
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s cyc=%0d kind=%0d strobes got=%b exp=%b in_addr got=%0d exp=%0d filt_addr got=%0d exp=%0d filt_sel got=%0d exp=%0d out_addr got=%0d exp=%0d",
                 tag, cyc, kind, o_str, e_str, o_in, e_in, o_fa, e_fa, o_fs, e_fs, o_oa, e_oa);
      end
      if (e == abort_evt) begin
        // Reset lands between edges to prove it acts without a clock.
        #2 rst = 1'b1;
        if (sel) start2 = 1'b0; else start1 = 1'b0;
        #1 sample_outputs(sel);
        checks++;
        if ({o_str, o_in, o_fa, o_fs, o_oa} !== '0) begin
          errors++;
          $display("FAIL %s_async_reset strobes got=%b exp=00000 in=%0d fa=%0d fs=%0d oa=%0d exp all 0",
                   tag, o_str, o_in, o_fa, o_fs, o_oa);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) begin
          @(negedge clk);
          sample_outputs(sel);
          checks++;
          if ({o_str, o_in, o_fa, o_fs, o_oa} !== '0) begin
            errors++;
            $display("FAIL %s_post_reset_idle strobes got=%b exp=00000 in=%0d fa=%0d fs=%0d oa=%0d exp all 0",
                     tag, o_str, o_in, o_fa, o_fs, o_oa);
          end
        end
        @(posedge clk); #1;
        return;
      end
      if (!(kind == 2 && !rdy)) e++;
      @(posedge clk); #1;
      cyc++;
    end
    if (sel) start2 = 1'b0; else start1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start1 = 1'b1; start2 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sample_outputs(s[0]);
      checks++;
      if ({o_str, o_in, o_fa, o_fs, o_oa} !== '0) begin
        errors++;
        $display("FAIL reset_state dut=%0d strobes got=%b exp=00000 in=%0d fa=%0d fs=%0d oa=%0d exp all 0",
                 s, o_str, o_in, o_fa, o_fs, o_oa);
      end
    end
    @(posedge clk); #1 rst = 1'b0; start1 = 1'b0; start2 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      sample_outputs(1'b0);
      checks++;
      if ({o_str, o_in, o_fa, o_fs, o_oa} !== '0) begin
        errors++;
        $display("FAIL idle_after_reset strobes got=%b exp=00000 in=%0d fa=%0d fs=%0d oa=%0d exp all 0",
                 o_str, o_in, o_fa, o_fs, o_oa);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_run();
    run_checked(1'b0, 4, 4, 16, 1, 0, 0, -1, 0, -1, "full_run");
  endtask

  task automatic test_stall();
    run_checked(1'b0, 4, 4, 16, 1, 0, 0, 13, 5, -1, "stall_addr13");
  endtask

  task automatic test_back_to_back();
    run_checked(1'b0, 4, 4, 16, 1, 0, 40, -1, 0, -1, "start_noise");
    run_checked(1'b0, 4, 4, 16, 1, 25, 40, -1, 0, -1, "back_to_back");
  endtask

  task automatic test_reset_mid_run();
    // Filter 2 first MAC is list entry 1 + 2*13*6 + 1 = 158.
    run_checked(1'b0, 4, 4, 16, 1, 10, 20, -1, 0, 158 + int'($urandom_range(0, 3)), "abort");
    run_checked(1'b0, 4, 4, 16, 1, 20, 0, -1, 0, -1, "after_abort");
  endtask

  task automatic test_small_config();
    run_checked(1'b1, 2, 4, 8, 2, 0, 0, -1, 0, -1, "small_cfg");
    run_checked(1'b1, 2, 4, 8, 2, 30, 30, -1, 0, -1, "small_cfg_stall");
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_stall();
    test_back_to_back();
    test_reset_mid_run();
    test_small_config();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
